// File: rtl/wb_excp_commit_pkg.sv
// Shared constants for the write-back / exception-commit stage: exception
// codes, CP0 register numbers, default vectors and the commit FSM states.
package wb_excp_commit_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_MOD  = 5'h01;
  localparam logic [4:0] EXC_TLBL = 5'h02;
  localparam logic [4:0] EXC_TLBS = 5'h03;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;

  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [31:0] EX_VEC_DEF     = 32'hBFC00380;
  localparam logic [31:0] REFILL_VEC_DEF = 32'hBFC00200;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ws_state_e;

  function automatic logic is_tlb_excode(input logic [4:0] code);
    return (code == EXC_TLBL) || (code == EXC_TLBS);
  endfunction

endpackage

// File: rtl/wb_excp_commit_excp_prio.sv
// Combinational exception priority selector: interrupt > captured exception
// > eret > refetch, producing the final ex/excode and the redirect PC.
import wb_excp_commit_pkg::*;

module excp_prio #(
  parameter logic [31:0] EX_VEC     = EX_VEC_DEF,
  parameter logic [31:0] REFILL_VEC = REFILL_VEC_DEF
) (
  input  logic        valid_i,
  input  logic        interrupt_i,
  input  logic        ex_i,
  input  logic [4:0]  excode_i,
  input  logic        refill_i,
  input  logic        eret_i,
  input  logic        refetch_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] epc_i,
  output logic        ex_o,
  output logic [4:0]  excode_o,
  output logic        eret_o,
  output logic        flush_o,
  output logic [31:0] flush_pc_o
);

  logic refetch;
  logic is_refill;

  always_comb begin
    ex_o     = valid_i && (interrupt_i || ex_i);
    excode_o = interrupt_i ? EXC_INT : excode_i;
    eret_o   = valid_i && eret_i && !ex_o;
    refetch  = valid_i && refetch_i && !ex_o && !eret_o;
    flush_o  = ex_o || eret_o || refetch;
    // An interrupt rewrites excode to INT, so it can never take the refill vector.
    is_refill = refill_i && is_tlb_excode(excode_o);

    flush_pc_o = pc_i + 32'd4;
    if (ex_o) begin
      flush_pc_o = is_refill ? REFILL_VEC : EX_VEC;
    end else if (eret_o) begin
      flush_pc_o = epc_i;
    end
  end

endmodule

// File: rtl/wb_excp_commit.sv
// Write-back stage with exception/eret/refetch commit and CP0 strobes.
// Optional macro TLB_REFETCH_EN: tlbwi/tlbr/mtc0-EntryHi redirect to pc+4.
import wb_excp_commit_pkg::*;

module wb_excp_commit #(
  parameter logic [31:0] EX_VEC     = EX_VEC_DEF,
  parameter logic [31:0] REFILL_VEC = REFILL_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_to_ws_valid,
  output logic        ws_allow_in,
  input  logic [31:0] ms_pc,
  input  logic        ms_bd,
  input  logic        ms_ex,
  input  logic [4:0]  ms_excode,
  input  logic        ms_refill,
  input  logic [31:0] ms_badvaddr,
  input  logic        ms_eret,
  input  logic        ms_mtc0,
  input  logic        ms_mfc0,
  input  logic        ms_tlbp,
  input  logic        ms_tlbr,
  input  logic        ms_tlbwi,
  input  logic [4:0]  ms_c0_addr,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_result,
  input  logic        interrupt,
  input  logic [31:0] c0_rdata,
  input  logic [31:0] c0_epc,
  output logic        wb_ex,
  output logic [4:0]  wb_excode,
  output logic        wb_bd,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_badvaddr,
  output logic        eret_flush,
  output logic        mtc0_we,
  output logic [4:0]  c0_addr,
  output logic [31:0] c0_wdata,
  output logic        tlbp,
  output logic        tlbr,
  output logic        tlbwi,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  ws_state_e state_q, state_d;
  logic      ws_valid_q, ws_valid_d;
  logic      ws_load;
  logic      vld;
  logic      refetch_req;

  logic [31:0] ws_pc_q, ws_badvaddr_q, ws_result_q;
  logic        ws_bd_q, ws_ex_q, ws_refill_q, ws_eret_q;
  logic        ws_mtc0_q, ws_mfc0_q, ws_tlbp_q, ws_tlbr_q, ws_tlbwi_q, ws_gr_we_q;
  logic [4:0]  ws_excode_q, ws_c0_addr_q, ws_dest_q;

  // The instruction behind a flushing commit is younger and must be dropped.
  assign ws_load    = ms_to_ws_valid && ws_allow_in && !flush;
  assign ws_valid_d = ws_load;
  assign vld        = ws_valid_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      ws_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ws_valid_q <= ws_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ws_load) begin
      ws_pc_q       <= ms_pc;
      ws_bd_q       <= ms_bd;
      ws_ex_q       <= ms_ex;
      ws_excode_q   <= ms_excode;
      ws_refill_q   <= ms_refill;
      ws_badvaddr_q <= ms_badvaddr;
      ws_eret_q     <= ms_eret;
      ws_mtc0_q     <= ms_mtc0;
      ws_mfc0_q     <= ms_mfc0;
      ws_tlbp_q     <= ms_tlbp;
      ws_tlbr_q     <= ms_tlbr;
      ws_tlbwi_q    <= ms_tlbwi;
      ws_c0_addr_q  <= ms_c0_addr;
      ws_gr_we_q    <= ms_gr_we;
      ws_dest_q     <= ms_dest;
      ws_result_q   <= ms_result;
    end
  end

  always_comb begin
    state_d     = state_q;
    ws_allow_in = 1'b0;
    case (state_q)
      ST_RUN: begin
        ws_allow_in = 1'b1;
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

`ifdef TLB_REFETCH_EN
  assign refetch_req = ws_tlbwi_q || ws_tlbr_q ||
                       (ws_mtc0_q && (ws_c0_addr_q == CP0_ENTRYHI));
`else
  assign refetch_req = 1'b0;
`endif

  excp_prio #(
    .EX_VEC     (EX_VEC),
    .REFILL_VEC (REFILL_VEC)
  ) u_prio (
    .valid_i     (vld),
    .interrupt_i (interrupt),
    .ex_i        (ws_ex_q),
    .excode_i    (ws_excode_q),
    .refill_i    (ws_refill_q),
    .eret_i      (ws_eret_q),
    .refetch_i   (refetch_req),
    .pc_i        (ws_pc_q),
    .epc_i       (c0_epc),
    .ex_o        (wb_ex),
    .excode_o    (wb_excode),
    .eret_o      (eret_flush),
    .flush_o     (flush),
    .flush_pc_o  (flush_pc)
  );

  assign wb_bd       = ws_bd_q;
  assign wb_pc       = ws_pc_q;
  assign wb_badvaddr = ws_badvaddr_q;

  assign mtc0_we  = vld && ws_mtc0_q  && !wb_ex;
  assign tlbp     = vld && ws_tlbp_q  && !wb_ex;
  assign tlbr     = vld && ws_tlbr_q  && !wb_ex;
  assign tlbwi    = vld && ws_tlbwi_q && !wb_ex;
  assign c0_addr  = ws_c0_addr_q;
  assign c0_wdata = ws_result_q;

  assign rf_we    = vld && ws_gr_we_q && !wb_ex;
  assign rf_waddr = ws_dest_q;
  assign rf_wdata = ws_mfc0_q ? c0_rdata : ws_result_q;

endmodule

// File: tb/tb_wb_excp_commit.sv
// Scoreboard bench for wb_excp_commit: directed commits push expected
// responses, a negedge monitor pops and compares on every strobe.
module tb_wb_excp_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allow_in;
  logic [31:0] ms_pc;
  logic        ms_bd, ms_ex;
  logic [4:0]  ms_excode;
  logic        ms_refill;
  logic [31:0] ms_badvaddr;
  logic        ms_eret, ms_mtc0, ms_mfc0, ms_tlbp, ms_tlbr, ms_tlbwi;
  logic [4:0]  ms_c0_addr;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        interrupt;
  logic [31:0] c0_rdata, c0_epc;
  logic        wb_ex;
  logic [4:0]  wb_excode;
  logic        wb_bd;
  logic [31:0] wb_pc, wb_badvaddr;
  logic        eret_flush, mtc0_we;
  logic [4:0]  c0_addr;
  logic [31:0] c0_wdata;
  logic        tlbp, tlbr, tlbwi, flush;
  logic [31:0] flush_pc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  wb_excp_commit dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allow_in(ws_allow_in),
    .ms_pc(ms_pc), .ms_bd(ms_bd), .ms_ex(ms_ex), .ms_excode(ms_excode),
    .ms_refill(ms_refill), .ms_badvaddr(ms_badvaddr), .ms_eret(ms_eret),
    .ms_mtc0(ms_mtc0), .ms_mfc0(ms_mfc0), .ms_tlbp(ms_tlbp), .ms_tlbr(ms_tlbr),
    .ms_tlbwi(ms_tlbwi), .ms_c0_addr(ms_c0_addr), .ms_gr_we(ms_gr_we),
    .ms_dest(ms_dest), .ms_result(ms_result),
    .interrupt(interrupt), .c0_rdata(c0_rdata), .c0_epc(c0_epc),
    .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_bd(wb_bd), .wb_pc(wb_pc),
    .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush), .mtc0_we(mtc0_we),
    .c0_addr(c0_addr), .c0_wdata(c0_wdata), .tlbp(tlbp), .tlbr(tlbr),
    .tlbwi(tlbwi), .flush(flush), .flush_pc(flush_pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        bd, ex;
    logic [4:0]  excode;
    logic        refill;
    logic [31:0] badv;
    logic        eret, mtc0, mfc0, tlbp, tlbr, tlbwi;
    logic [4:0]  c0a;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } ms_t;

  typedef struct packed {
    logic        wb_ex;
    logic [4:0]  excode;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] badv;
    logic        eret_flush, mtc0_we, tlbp, tlbr, tlbwi, flush;
    logic [31:0] flush_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  c0_addr;
    logic [31:0] c0_wdata;
  } exp_t;

  exp_t sb[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic logic any_strobe();
    return wb_ex | eret_flush | mtc0_we | tlbp | tlbr | tlbwi | rf_we | flush;
  endfunction

  task automatic drive(input ms_t m, input logic v);
    ms_to_ws_valid = v;
    ms_pc = m.pc; ms_bd = m.bd; ms_ex = m.ex; ms_excode = m.excode;
    ms_refill = m.refill; ms_badvaddr = m.badv; ms_eret = m.eret;
    ms_mtc0 = m.mtc0; ms_mfc0 = m.mfc0; ms_tlbp = m.tlbp; ms_tlbr = m.tlbr;
    ms_tlbwi = m.tlbwi; ms_c0_addr = m.c0a; ms_gr_we = m.gr_we;
    ms_dest = m.dest; ms_result = m.result;
  endtask

  // One instruction: MEM-valid cycle, then its WB cycle (interrupt applied there).
  task automatic issue(input ms_t m, input logic intr, input exp_t x);
    sb.push_back(x);
    drive(m, 1'b1);
    @(posedge clk); #1;
    ms_to_ws_valid = 1'b0;
    interrupt = intr;
    @(posedge clk); #1;
    interrupt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!reset && any_strobe()) begin
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_commit: got strobes with empty scoreboard, pc %h", wb_pc);
        end else begin
          x = sb.pop_front();
          chk("wb_ex", wb_ex, x.wb_ex);
          chk("eret_flush", eret_flush, x.eret_flush);
          chk("mtc0_we", mtc0_we, x.mtc0_we);
          chk("tlbp", tlbp, x.tlbp);
          chk("tlbr", tlbr, x.tlbr);
          chk("tlbwi", tlbwi, x.tlbwi);
          chk("flush", flush, x.flush);
          chk("rf_we", rf_we, x.rf_we);
          if (x.wb_ex) begin
            chk("wb_excode", wb_excode, x.excode);
            chk("wb_bd", wb_bd, x.bd);
            chk("wb_pc", wb_pc, x.pc);
            chk("wb_badvaddr", wb_badvaddr, x.badv);
          end
          if (x.flush) chk("flush_pc", flush_pc, x.flush_pc);
          if (x.rf_we) begin
            chk("rf_waddr", rf_waddr, x.rf_waddr);
            chk("rf_wdata", rf_wdata, x.rf_wdata);
          end
          if (x.mtc0_we) begin
            chk("c0_addr", c0_addr, x.c0_addr);
            chk("c0_wdata", c0_wdata, x.c0_wdata);
          end
          if (x.flush) begin
            @(negedge clk);
            chk("allow_in_after_flush", ws_allow_in, 1'b0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ms_t  m;
    exp_t x;
    reset = 1'b1;
    interrupt = 1'b0;
    c0_rdata = 32'h0000_1234;
    c0_epc = 32'h8000_2000;
    m = '0;
    m.pc = 32'h8000_0000; m.gr_we = 1'b1; m.dest = 5'd1; m.result = 32'h1;
    drive(m, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", any_strobe(), 1'b0);
    chk("reset_allow_in", ws_allow_in, 1'b1);
    drive(m, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_strobes", any_strobe(), 1'b0);

    // syscall
    m = '0; m.pc = 32'h8000_1000; m.ex = 1'b1; m.excode = 5'h08;
    m.gr_we = 1'b1; m.dest = 5'd3; m.result = 32'hAAAA_0003;
    x = '0; x.wb_ex = 1'b1; x.excode = 5'h08; x.pc = 32'h8000_1000;
    x.flush = 1'b1; x.flush_pc = 32'hBFC0_0380;
    issue(m, 1'b0, x);

    // plain add
    m = '0; m.pc = 32'h8000_0010; m.gr_we = 1'b1; m.dest = 5'd9; m.result = 32'h0000_0055;
    x = '0; x.rf_we = 1'b1; x.rf_waddr = 5'd9; x.rf_wdata = 32'h0000_0055;
    issue(m, 1'b0, x);

    // interrupt on an add in a delay slot
    m = '0; m.pc = 32'h8000_0204; m.bd = 1'b1; m.gr_we = 1'b1; m.dest = 5'd5; m.result = 32'h7;
    x = '0; x.wb_ex = 1'b1; x.excode = 5'h00; x.bd = 1'b1; x.pc = 32'h8000_0204;
    x.flush = 1'b1; x.flush_pc = 32'hBFC0_0380;
    issue(m, 1'b1, x);

    // interrupt overriding a pending TLBL refill: general vector, excode 0
    m = '0; m.pc = 32'h8000_0300; m.ex = 1'b1; m.excode = 5'h02; m.refill = 1'b1;
    m.badv = 32'h0040_0000;
    x = '0; x.wb_ex = 1'b1; x.excode = 5'h00; x.pc = 32'h8000_0300; x.badv = 32'h0040_0000;
    x.flush = 1'b1; x.flush_pc = 32'hBFC0_0380;
    issue(m, 1'b1, x);

    // TLBL refill / non-refill
    m = '0; m.pc = 32'h8000_0100; m.ex = 1'b1; m.excode = 5'h02; m.refill = 1'b1;
    m.badv = 32'h0040_0000; m.gr_we = 1'b1; m.dest = 5'd4;
    x = '0; x.wb_ex = 1'b1; x.excode = 5'h02; x.pc = 32'h8000_0100; x.badv = 32'h0040_0000;
    x.flush = 1'b1; x.flush_pc = 32'hBFC0_0200;
    issue(m, 1'b0, x);
    m.refill = 1'b0;
    x.flush_pc = 32'hBFC0_0380;
    issue(m, 1'b0, x);

    // TLBS refill
    m = '0; m.pc = 32'h8000_0140; m.ex = 1'b1; m.excode = 5'h03; m.refill = 1'b1;
    m.badv = 32'h0050_0000;
    x = '0; x.wb_ex = 1'b1; x.excode = 5'h03; x.pc = 32'h8000_0140; x.badv = 32'h0050_0000;
    x.flush = 1'b1; x.flush_pc = 32'hBFC0_0200;
    issue(m, 1'b0, x);

    // eret
    m = '0; m.pc = 32'h8000_0400; m.eret = 1'b1;
    x = '0; x.eret_flush = 1'b1; x.flush = 1'b1; x.flush_pc = 32'h8000_2000;
    issue(m, 1'b0, x);

    // eret with ADEL: exception wins
    m = '0; m.pc = 32'h8000_0404; m.eret = 1'b1; m.ex = 1'b1; m.excode = 5'h04;
    m.badv = 32'h8000_0405;
    x = '0; x.wb_ex = 1'b1; x.excode = 5'h04; x.pc = 32'h8000_0404; x.badv = 32'h8000_0405;
    x.flush = 1'b1; x.flush_pc = 32'hBFC0_0380;
    issue(m, 1'b0, x);

    // mtc0 Status: never a refetch
    m = '0; m.pc = 32'h8000_0500; m.mtc0 = 1'b1; m.c0a = 5'd12; m.result = 32'h0000_FF01;
    x = '0; x.mtc0_we = 1'b1; x.c0_addr = 5'd12; x.c0_wdata = 32'h0000_FF01;
    issue(m, 1'b0, x);

    // tlbwi
    m = '0; m.pc = 32'h8000_3000; m.tlbwi = 1'b1;
    x = '0; x.tlbwi = 1'b1;
`ifdef TLB_REFETCH_EN
    x.flush = 1'b1; x.flush_pc = 32'h8000_3004;
`endif
    issue(m, 1'b0, x);

    // mtc0 EntryHi
    m = '0; m.pc = 32'h8000_3100; m.mtc0 = 1'b1; m.c0a = 5'd10; m.result = 32'h0000_2000;
    x = '0; x.mtc0_we = 1'b1; x.c0_addr = 5'd10; x.c0_wdata = 32'h0000_2000;
`ifdef TLB_REFETCH_EN
    x.flush = 1'b1; x.flush_pc = 32'h8000_3104;
`endif
    issue(m, 1'b0, x);

    // tlbp
    m = '0; m.pc = 32'h8000_3200; m.tlbp = 1'b1;
    x = '0; x.tlbp = 1'b1;
    issue(m, 1'b0, x);

    // reset in the FLUSH cycle of a syscall
    m = '0; m.pc = 32'h8000_1000; m.ex = 1'b1; m.excode = 5'h08;
    x = '0; x.wb_ex = 1'b1; x.excode = 5'h08; x.pc = 32'h8000_1000;
    x.flush = 1'b1; x.flush_pc = 32'hBFC0_0380;
    sb.push_back(x);
    drive(m, 1'b1);
    @(posedge clk); #1;
    ms_to_ws_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_allow_in", ws_allow_in, 1'b1);
    chk("post_reset_strobes", any_strobe(), 1'b0);
    @(posedge clk); #1;

    // mfc0 after reset
    m = '0; m.pc = 32'h8000_1004; m.mfc0 = 1'b1; m.gr_we = 1'b1; m.dest = 5'd8;
    m.c0a = 5'd12; m.result = 32'hDEAD_BEEF;
    x = '0; x.rf_we = 1'b1; x.rf_waddr = 5'd8; x.rf_wdata = 32'h0000_1234;
    issue(m, 1'b0, x);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain: %0d expected commits never seen, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_excp_commit.md
WB_EXCP_COMMIT -- requirements
Module: wb_excp_commit

Interface
REQ-001 SHALL have parameter EX_VEC, default 32'hBFC00380, general exception entry PC.
REQ-002 SHALL have parameter REFILL_VEC, default 32'hBFC00200, TLB-refill entry PC.
REQ-003 SHALL have ports clk in 1 (single clock) and reset in 1 (synchronous, active-high).
REQ-004 SHALL have upstream handshake ports ms_to_ws_valid in 1 and ws_allow_in out 1.
REQ-005 SHALL have MEM-stage inputs ms_pc 32, ms_bd 1, ms_ex 1, ms_excode 5, ms_refill 1, ms_badvaddr 32, ms_eret 1, ms_mtc0 1, ms_mfc0 1, ms_tlbp 1, ms_tlbr 1, ms_tlbwi 1, ms_c0_addr 5, ms_gr_we 1, ms_dest 5, ms_result 32.
REQ-006 SHALL have CP0-return inputs interrupt 1, c0_rdata 32 and c0_epc 32.
REQ-007 SHALL have CP0-drive outputs wb_ex 1, wb_excode 5, wb_bd 1, wb_pc 32, wb_badvaddr 32, eret_flush 1, mtc0_we 1, c0_addr 5, c0_wdata 32, tlbp 1, tlbr 1, tlbwi 1.
REQ-008 SHALL have pipeline outputs flush 1 and flush_pc 32, plus register-file outputs rf_we 1, rf_waddr 5, rf_wdata 32.

Function
REQ-009 SHALL hold a single WB entry (ws_valid plus the captured fields), loaded when ms_to_ws_valid && ws_allow_in.
REQ-010 SHALL drive ws_allow_in = 1 in state RUN and 0 in state FLUSH; each WB entry retires in one cycle.
REQ-011 SHALL use FSM states RUN and FLUSH.
REQ-012 SHALL move RUN->FLUSH when a valid entry commits with an exception, an eret or a refetch condition; FLUSH->RUN SHALL follow unconditionally after one cycle.
REQ-013 SHALL evaluate interrupt on the cycle the entry is valid in WB; if interrupt=1, the entry SHALL take excode 5'h00, overriding ms_ex/ms_excode, with bd kept.
REQ-014 SHALL compute exception priority as: interrupt, then the captured ms_ex, then eret; eret together with an exception SHALL be treated as the exception.
REQ-015 SHALL drive wb_ex = ws_valid && (interrupt || ex) for exactly one cycle per entry; wb_pc, wb_bd, wb_badvaddr and wb_excode SHALL come from the entry.
REQ-016 SHALL drive eret_flush = ws_valid && eret && !wb_ex.
REQ-017 SHALL drive mtc0_we, tlbp, tlbr and tlbwi as the matching ws field && ws_valid && !wb_ex.
REQ-018 SHALL drive c0_addr = the entry's c0_addr and c0_wdata = the entry's result.
REQ-019 SHALL drive rf_we = ws_valid && gr_we && !wb_ex, rf_waddr = dest, and rf_wdata = c0_rdata if mfc0 else result.
REQ-020 SHALL assert flush as a one-cycle pulse in the cycle of the triggering commit (combinational from the WB entry).
REQ-021 SHALL select flush_pc as: REFILL_VEC if the exception is a refill (excode 5'h02/5'h03 with refill=1); EX_VEC for any other exception; c0_epc for eret; ws_pc+4 for a refetch.
REQ-022 SHALL discard the WB entry in the commit cycle, so no entry is valid in FLUSH; upstream data presented during FLUSH SHALL NOT be captured.
REQ-023 SHALL NOT let an instruction that is not ws_valid drive any CP0 or RF strobe.

Reset
REQ-024 On reset, SHALL set state=RUN and ws_valid=0, and force all strobes (wb_ex, eret_flush, mtc0_we, tlbp, tlbr, tlbwi, rf_we, flush) low.
REQ-025 Reset SHALL override an in-flight FLUSH: the next cycle is RUN with ws_allow_in=1.
REQ-026 Data fields SHALL need no reset.

Configuration
REQ-027 With macro TLB_REFETCH_EN defined, the refetch condition SHALL be ws_valid && !wb_ex && (tlbwi || tlbr || (mtc0 && c0_addr==EntryHi(10))).
REQ-028 Without TLB_REFETCH_EN, the refetch condition SHALL be constant 0, and those instructions SHALL retire without flush.

Structure
REQ-029 The shared package SHALL hold the excode constants (INT=0, MOD=1, TLBL=2, TLBS=3, ADEL=4, ADES=5), the CP0 register numbers, and the default vectors.
REQ-030 SHALL contain one sub-module, excp_prio: a combinational selector producing the final ex, excode and flush_pc.

Verification
REQ-031 SHALL cover: syscall entry at pc 0x80001000, bd=0, excode 8 -> wb_ex=1, wb_excode=8, flush=1, flush_pc=0xBFC00380, rf_we=0, ws_allow_in=0 the next cycle.
REQ-032 SHALL cover: interrupt=1 during an add in WB at a delay slot, pc 0x80000204 -> wb_excode=0, wb_bd=1, rf_we=0.
REQ-033 SHALL cover: TLBL with refill=1, badvaddr 0x00400000 -> flush_pc=0xBFC00200, wb_badvaddr=0x00400000; the same with refill=0 -> flush_pc=0xBFC00380.
REQ-034 SHALL cover: eret with c0_epc=0x80002000 -> eret_flush=1, flush_pc=0x80002000, wb_ex=0.
REQ-035 SHALL cover: tlbwi at pc 0x80003000 -> with TLB_REFETCH_EN, tlbwi=1, flush=1, flush_pc=0x80003004; without it, tlbwi=1 and flush=0.
REQ-036 SHALL cover: reset asserted in the FLUSH cycle -> RUN next cycle, all strobes 0; an mfc0 with c0_rdata=0x1234 afterwards -> rf_wdata=0x1234.
